f_pc_npc_unit: RTL and testbench
================================

// Module: f_pc_npc_unit
// PURPOSE
//   Fetch-stage program counter, next-PC selection and F/D pipeline register.
//   Consumes the D-stage branch decision (branch_taken) and D-stage jump decode.
//   Redirects fetch one cycle after D resolves; the MIPS delay slot is always fetched.
//   Drives the IM address (pc_f) and feeds instr_d/pc_d to the decode stage.
// PARAMETERS
//   RESET_PC   32'h0000_3000  PC value loaded on reset
//   IM_WORDS   4096           IM depth in words; a fetch beyond it raises pc_oor
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   stall        in   1   hazard-unit stall; holds PC and F/D
//   instr_f      in   32  instruction read from IM at pc_f
//   branch_taken in   1   D-stage branch condition result; 1 = branch is taken
//   d_is_branch  in   1   instruction in D is a conditional branch
//   d_jtype      in   2   00 none, 01 j/jal (imm26), 10 jr/jalr (register), 11 reserved (= none)
//   d_imm16      in   16  branch offset of instruction in D
//   d_imm26      in   26  jump index of instruction in D
//   d_rs_val     in   32  forwarded rs value in D, used as the jr target
//   d_likely     in   1   D branch is a "likely" variant (used only with NPC_LIKELY_EN)
//   pc_f         out  32  current fetch PC, sent to IM
//   npc          out  32  combinational next PC
//   instr_d      out  32  F/D register: instruction
//   pc_d         out  32  F/D register: PC of instr_d
//   valid_d      out  1   F/D register: instr_d is a real instruction
//   pc_err       out  1   pc_f[1:0] != 0 (misaligned fetch)
//   pc_oor       out  1   pc_f outside [RESET_PC, RESET_PC + 4*IM_WORDS)
// BEHAVIOUR
//   Reset (wins over stall): pc_f = RESET_PC; instr_d = 0 (nop); pc_d = 0; valid_d = 0.
//   npc priority, evaluated from D-stage inputs:
//     1. d_is_branch & branch_taken: pc_d + 4 + (sext(d_imm16) << 2), 32-bit wrap.
//     2. d_jtype == 01: {pc_d[31:28], d_imm26, 2'b00}.
//     3. d_jtype == 10: d_rs_val, taken verbatim (no alignment masking).
//     4. Otherwise: pc_f + 4, wrapping at 32'hFFFF_FFFC to 0.
//   Clock edge, no stall: pc_f <= npc; instr_d <= instr_f; pc_d <= pc_f; valid_d <= 1.
//   Clock edge, stall: pc_f, instr_d, pc_d and valid_d all hold.
//     - The D-stage decision is ignored during stall.
//     - The same D instruction is re-evaluated on the first non-stall cycle.
//   Redirect latency: target appears on pc_f one edge after the branch/jump sits in D.
//     The instruction fetched in that same cycle (the delay slot) enters D normally.
//   Branch and jump asserted together: the branch wins; the bench flags it as illegal decode.
//   pc_err and pc_oor are combinational from pc_f.
//     - The PC keeps advancing; no trap is taken.
//     - Reset values: pc_err = 0; pc_oor = 0 for any legal RESET_PC.
//   Reset mid-stall or mid-redirect: all state returns to reset values next edge; the pending target is discarded.
// CONFIGURATION
//   NPC_LIKELY_EN defined:
//     - Condition: d_is_branch & d_likely & !branch_taken & !stall.
//     - Then the F/D register loads instr_d = 0, valid_d = 0, pc_d = pc_f (delay slot annulled).
//     - pc_f still advances to pc_f + 4.
//   NPC_LIKELY_EN undefined: d_likely is ignored; the delay slot always executes.
// TESTING
//   1. Reset held 2 cycles, then released:
//      -> pc_f = 0x3000, valid_d = 0; then pc_f goes 0x3004, 0x3008;
//         pc_d = 0x3000 on the second edge.
//   2. beq in D at pc_d = 0x3008, imm16 = 0x0004, branch_taken = 1:
//      -> next pc_f = 0x301C; delay slot 0x300C enters D with valid_d = 1.
//   3. Backward branch, pc_d = 0x3010, imm16 = 0xFFFC, taken:
//      -> pc_f = 0x3004. Same branch with branch_taken = 0 -> pc_f = pc_f + 4.
//   4. stall = 1 for 3 cycles with a jr in D (d_rs_val = 0x3400), then released:
//      -> pc_f, instr_d and pc_d are constant for the 3 cycles;
//         pc_f = 0x3400 one edge after release.
//   5. j with d_imm26 = 0x0000C10, pc_d = 0x3000 -> pc_f = 0x0000_3040.
//      jr with d_rs_val = 0x3002 -> pc_err = 1.
//   6. NPC_LIKELY_EN build, likely branch not taken at pc_d = 0x3008:
//      -> instr_d = 0, valid_d = 0 next edge; pc_f = 0x3010.
//      Without the macro: valid_d = 1 and instr_d = delay slot.

Source files
------------

// File: rtl/f_pc_npc_unit_if.sv
// Fetch/decode bus between the PC unit and its neighbours (hazard unit, IM, D stage).
// Ports: slave modport = PC unit view (D-stage decisions and IM data in, fetch PC and F/D register out);
//        master modport = view of the surrounding pipeline that drives those decisions.
interface f_pc_npc_unit_if;
  // Control and D-stage decode inputs to the PC unit
  logic        stall;
  logic [31:0] instr_f;
  logic        branch_taken;
  logic        d_is_branch;
  logic [1:0]  d_jtype;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_val;
  logic        d_likely;
  // Fetch PC and F/D register outputs
  logic [31:0] pc_f;
  logic [31:0] npc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        pc_err;
  logic        pc_oor;

  modport slave (
    input  stall, instr_f, branch_taken, d_is_branch, d_jtype,
           d_imm16, d_imm26, d_rs_val, d_likely,
    output pc_f, npc, instr_d, pc_d, valid_d, pc_err, pc_oor
  );

  modport master (
    output stall, instr_f, branch_taken, d_is_branch, d_jtype,
           d_imm16, d_imm26, d_rs_val, d_likely,
    input  pc_f, npc, instr_d, pc_d, valid_d, pc_err, pc_oor
  );
endinterface

// File: rtl/f_pc_npc_unit.sv
// Fetch PC, next-PC select and F/D pipeline register for a MIPS-style pipeline with a delay slot.
// Latency: redirect reaches pc_f one edge after the branch/jump sits in D; npc is combinational.
// Backpressure: stall freezes pc_f and the F/D register; the D decision is re-evaluated once stall drops.
// Ports: clk, reset (sync, active-high); bus (slave modport of f_pc_npc_unit_if) carrying
//        stall, instr_f and D-stage decode in; pc_f, npc, instr_d, pc_d, valid_d, pc_err, pc_oor out.
// Optional feature macro: NPC_LIKELY_EN (annuls the delay slot of a not-taken "likely" branch).
module f_pc_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  f_pc_npc_unit_if.slave        bus
);

  // IM window bounds held at 33 bits so RESET_PC + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] IM_LO = {1'b0, RESET_PC};
  localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pcd_q;
  logic        valid_q;

  logic [31:0] npc_c;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        br_take;
  logic        annul;

  // Sequential targets; 32-bit adds wrap naturally (0xFFFF_FFFC + 4 -> 0).
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pcd_q + 32'd4 + {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
  assign j_target  = {pcd_q[31:28], bus.d_imm26, 2'b00};
  assign br_take   = bus.d_is_branch & bus.branch_taken;

  // Branch outranks jumps so an illegal branch+jump decode still has a defined target.
  always_comb begin
    npc_c = pc_plus4;
    if (br_take) begin
      npc_c = br_target;
    end else if (bus.d_jtype == 2'b01) begin
      npc_c = j_target;
    end else if (bus.d_jtype == 2'b10) begin
      npc_c = bus.d_rs_val;
    end
  end

`ifdef NPC_LIKELY_EN
  // Not-taken likely branch: the delay slot being fetched now is squashed on its way into D.
  assign annul = bus.d_is_branch & bus.d_likely & ~bus.branch_taken;
`else
  assign annul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcd_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q  <= npc_c;
      pcd_q <= pc_q;
      if (annul) begin
        instr_q <= 32'd0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= bus.instr_f;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.pc_f    = pc_q;
  assign bus.npc     = npc_c;
  assign bus.instr_d = instr_q;
  assign bus.pc_d    = pcd_q;
  assign bus.valid_d = valid_q;
  // Status flags only; fetch keeps running when they are raised.
  assign bus.pc_err  = |pc_q[1:0];
  assign bus.pc_oor  = ({1'b0, pc_q} < IM_LO) || ({1'b0, pc_q} >= IM_HI);

endmodule

// File: tb/tb_f_pc_npc_unit.sv
// Testbench for f_pc_npc_unit: directed scenarios with literal expectations, then randomized
// stimulus checked every cycle against a behavioural model of the fetch/next-PC rules.
module tb_f_pc_npc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam longint      IM_BYTES = 4 * 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] salt = 32'hFFFF_FFFF;
  logic chk_en = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  f_pc_npc_unit_if bus ();

  f_pc_npc_unit #(.RESET_PC(RST_PC), .IM_WORDS(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // IM stand-in: the instruction word is a scrambled copy of its address.
  assign bus.instr_f = bus.pc_f ^ salt;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_valid;

  function automatic logic [31:0] model_npc();
    longint t;
    if (bus.d_is_branch && bus.branch_taken)
      t = longint'(m_pcd) + 4 + 4 * longint'($signed(bus.d_imm16));
    else if (bus.d_jtype == 2'd1)
      t = (longint'(m_pcd) / 268435456) * 268435456 + 4 * longint'(bus.d_imm26);
    else if (bus.d_jtype == 2'd2)
      t = longint'(bus.d_rs_val);
    else
      t = longint'(m_pc) + 4;
    return t[31:0];
  endfunction

  always @(posedge clk) begin
    logic [31:0] nxt;
    logic        ann;
    if (reset) begin
      m_pc = RST_PC; m_instr = 32'd0; m_pcd = 32'd0; m_valid = 1'b0;
    end else if (!bus.stall) begin
      nxt = model_npc();
`ifdef NPC_LIKELY_EN
      ann = bus.d_is_branch && bus.d_likely && !bus.branch_taken;
`else
      ann = 1'b0;
`endif
      m_pcd   = m_pc;
      m_instr = ann ? 32'd0 : bus.instr_f;
      m_valid = !ann;
      m_pc    = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, once inputs have settled after the falling edge.
  always begin
    @(negedge clk);
    #4;
    if (chk_en) begin
      chk("m_pc_f",    bus.pc_f,    m_pc);
      chk("m_npc",     bus.npc,     model_npc());
      chk("m_instr_d", bus.instr_d, m_instr);
      chk("m_pc_d",    bus.pc_d,    m_pcd);
      chk("m_valid_d", {31'd0, bus.valid_d}, {31'd0, m_valid});
      chk("m_pc_err",  {31'd0, bus.pc_err},  {31'd0, (m_pc % 4) != 0});
      chk("m_pc_oor",  {31'd0, bus.pc_oor},
          {31'd0, (longint'(m_pc) < longint'(RST_PC)) || (longint'(m_pc) >= longint'(RST_PC) + IM_BYTES)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_d();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.d_is_branch = 1'b0;
    bus.d_jtype = 2'd0; bus.d_imm16 = 16'd0; bus.d_imm26 = 26'd0;
    bus.d_rs_val = 32'd0; bus.d_likely = 1'b0;
  endtask

  // Advance one clock; returns just after the falling edge, where inputs may change.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    bus.d_jtype = 2'd2; bus.d_rs_val = tgt;
    cyc();
    clear_d();
    #1;
  endtask

  initial begin
    clear_d();
    reset = 1'b1;
    // 1. reset held two cycles
    cyc(); cyc();
    #1;
    chk("rst_pc_f", bus.pc_f, 32'h3000);
    chk("rst_valid", {31'd0, bus.valid_d}, 32'd0);
    chk("rst_instr", bus.instr_d, 32'd0);
    chk("rst_pc_d", bus.pc_d, 32'd0);
    chk("rst_err", {31'd0, bus.pc_err}, 32'd0);
    chk("rst_oor", {31'd0, bus.pc_oor}, 32'd0);
    chk_en = 1'b1;
    reset = 1'b0;
    cyc(); #1;
    chk("seq1_pc_f", bus.pc_f, 32'h3004);
    chk("seq1_pc_d", bus.pc_d, 32'h3000);
    chk("seq1_valid", {31'd0, bus.valid_d}, 32'd1);
    cyc(); #1;
    chk("seq2_pc_f", bus.pc_f, 32'h3008);
    cyc();
    // 2. forward beq at pc_d = 0x3008
    bus.d_is_branch = 1'b1; bus.branch_taken = 1'b1; bus.d_imm16 = 16'h0004;
    #1;
    chk("beq_pc_d", bus.pc_d, 32'h3008);
    chk("beq_npc", bus.npc, 32'h301C);
    cyc(); clear_d(); #1;
    chk("beq_pc_f", bus.pc_f, 32'h301C);
    chk("dslot_pc_d", bus.pc_d, 32'h300C);
    chk("dslot_instr", bus.instr_d, 32'hFFFF_CFF3);
    chk("dslot_valid", {31'd0, bus.valid_d}, 32'd1);
    // 3. backward branch at pc_d = 0x3010
    jr_to(32'h3010);
    cyc();
    bus.d_is_branch = 1'b1; bus.branch_taken = 1'b0; bus.d_imm16 = 16'hFFFC;
    #1;
    chk("bwd_nt_npc", bus.npc, 32'h3018);
    bus.branch_taken = 1'b1;
    #1;
    chk("bwd_t_npc", bus.npc, 32'h3004);
    cyc(); clear_d(); #1;
    chk("bwd_pc_f", bus.pc_f, 32'h3004);
    // 4. three stall cycles with jr 0x3400 in D
    bus.d_jtype = 2'd2; bus.d_rs_val = 32'h3400; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("stall_pc_f", bus.pc_f, 32'h3004);
      chk("stall_pc_d", bus.pc_d, 32'h3014);
      chk("stall_instr", bus.instr_d, 32'hFFFF_CFEB);
    end
    bus.stall = 1'b0;
    cyc(); clear_d(); #1;
    chk("unstall_pc_f", bus.pc_f, 32'h3400);
    // 5. j and misaligned / out-of-range jr targets
    bus.d_jtype = 2'd1; bus.d_imm26 = 26'h0000C10;
    cyc(); clear_d(); #1;
    chk("j_pc_f", bus.pc_f, 32'h3040);
    jr_to(32'h3002);
    chk("jr_mis_pc_f", bus.pc_f, 32'h3002);
    chk("jr_mis_err", {31'd0, bus.pc_err}, 32'd1);
    chk("jr_mis_oor", {31'd0, bus.pc_oor}, 32'd0);
    jr_to(32'h7000);
    chk("oor_hi", {31'd0, bus.pc_oor}, 32'd1);
    jr_to(32'h6FFC);
    chk("oor_top_in", {31'd0, bus.pc_oor}, 32'd0);
    jr_to(32'h2FFC);
    chk("oor_lo", {31'd0, bus.pc_oor}, 32'd1);
    jr_to(32'hFFFF_FFFC);
    chk("wrap_npc", bus.npc, 32'h0);
    cyc(); #1;
    chk("wrap_pc_f", bus.pc_f, 32'h0);
    // reset mid-redirect discards the pending jump
    bus.d_jtype = 2'd2; bus.d_rs_val = 32'h5000; reset = 1'b1;
    cyc(); reset = 1'b0; clear_d(); #1;
    chk("rst_mid_pc_f", bus.pc_f, 32'h3000);
    chk("rst_mid_valid", {31'd0, bus.valid_d}, 32'd0);
    cyc(); cyc(); cyc();
    // 6. likely branch not taken at pc_d = 0x3008
    bus.d_is_branch = 1'b1; bus.d_likely = 1'b1; bus.d_imm16 = 16'h0004;
    cyc(); clear_d(); #1;
    chk("likely_pc_f", bus.pc_f, 32'h3010);
    chk("likely_pc_d", bus.pc_d, 32'h300C);
`ifdef NPC_LIKELY_EN
    chk("likely_instr", bus.instr_d, 32'h0);
    chk("likely_valid", {31'd0, bus.valid_d}, 32'd0);
`else
    chk("likely_instr", bus.instr_d, 32'hFFFF_CFF3);
    chk("likely_valid", {31'd0, bus.valid_d}, 32'd1);
`endif
    // branch and jump together: branch target wins (pc_d = 0x300C)
    bus.d_is_branch = 1'b1; bus.branch_taken = 1'b1; bus.d_imm16 = 16'h0004;
    bus.d_jtype = 2'd1; bus.d_imm26 = 26'd0;
    #1;
    chk("br_jmp_npc", bus.npc, 32'h3020);
    cyc(); clear_d();

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      salt = $urandom;
      reset = ($urandom_range(0, 99) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.d_is_branch = ($urandom_range(0, 2) == 0);
      bus.branch_taken = $urandom_range(0, 1) != 0;
      bus.d_likely = $urandom_range(0, 1) != 0;
      bus.d_jtype = 2'($urandom_range(0, 3));
      bus.d_imm16 = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 64)) - 32);
      bus.d_imm26 = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'(32'h0C00 + $urandom_range(0, 4095));
      bus.d_rs_val = ($urandom_range(0, 3) == 0) ? $urandom : (RST_PC + 4 * $urandom_range(0, 4095));
      cyc();
    end
    reset = 1'b0;
    clear_d();
    cyc();
    chk_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
